// File: rtl/fft_cooley_tukey_folded_stage_if.sv
// Frame bundle shared by chained folded FFT stages: input frame handshake,
// output frame handshake and the static sine table feeding the twiddles.
interface fft_cooley_tukey_folded_stage_if #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
);
    logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_msg_real;
    logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_msg_imag;
    logic                                recv_inverse;
    logic                                recv_val;
    logic                                recv_rdy;
    logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg_real;
    logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg_imag;
    logic                                send_val;
    logic                                send_rdy;
    logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] sine_wave_out;

    modport slave (
        input  recv_msg_real, recv_msg_imag, recv_inverse, recv_val,
        output recv_rdy,
        output send_msg_real, send_msg_imag, send_val,
        input  send_rdy,
        input  sine_wave_out
    );

    modport master (
        output recv_msg_real, recv_msg_imag, recv_inverse, recv_val,
        input  recv_rdy,
        input  send_msg_real, send_msg_imag, send_val,
        output send_rdy,
        output sine_wave_out
    );
endinterface

// File: rtl/fft_cooley_tukey_folded_stage.sv
// One radix-2 DIT FFT stage that time-multiplexes N_BFLY butterfly units over
// the N_SAMPLES/2 butterflies of a frame, with per-frame inverse and optional 1/2 scaling.
module fft_cooley_tukey_folded_stage #(
    parameter int BIT_WIDTH  = 32,
    parameter int DECIMAL_PT = 16,
    parameter int N_SAMPLES  = 8,
    parameter int STAGE_FFT  = 0,
    parameter int N_BFLY     = 4,
    parameter int SCALE      = 0
) (
    input logic clk,
    input logic reset,
    fft_cooley_tukey_folded_stage_if.slave bus
);
    localparam int PASSES   = N_SAMPLES / (2 * N_BFLY);
    localparam int PW       = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int IW       = $clog2(N_SAMPLES);
    localparam int HALF     = 1 << STAGE_FFT;
    localparam int TW_SHIFT = IW - STAGE_FFT - 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] frame_t;

    state_t         r_state;
    logic [PW-1:0]  r_pass;
    frame_t         r_workReal;
    frame_t         r_workImag;
    logic           r_inverse;
    logic           r_sendVal;

    logic                 w_recvRdy;
    logic                 w_accept;
    logic [IW-1:0]        w_top   [N_BFLY];
    logic [IW-1:0]        w_bot   [N_BFLY];
    logic [IW-1:0]        w_tw    [N_BFLY];
    logic [BIT_WIDTH-1:0] w_wr    [N_BFLY];
    logic [BIT_WIDTH-1:0] w_wc    [N_BFLY];
    logic [BIT_WIDTH-1:0] w_pReal [N_BFLY];
    logic [BIT_WIDTH-1:0] w_pImag [N_BFLY];
    logic [BIT_WIDTH-1:0] w_cReal [N_BFLY];
    logic [BIT_WIDTH-1:0] w_cImag [N_BFLY];
    logic [BIT_WIDTH-1:0] w_dReal [N_BFLY];
    logic [BIT_WIDTH-1:0] w_dImag [N_BFLY];

    // Butterfly b lives in group b/H at offset j = b mod H; its partner sits H above.
    function automatic logic [IW-1:0] topIndex(input int b);
        return IW'(((b >> STAGE_FFT) << (STAGE_FFT + 1)) + (b & (HALF - 1)));
    endfunction

    function automatic logic [IW-1:0] twiddleIndex(input int b);
        return IW'((b & (HALF - 1)) << TW_SHIFT);
    endfunction

    function automatic logic [BIT_WIDTH-1:0] fxMul(input logic [BIT_WIDTH-1:0] a,
                                                    input logic [BIT_WIDTH-1:0] b);
        logic signed [2*BIT_WIDTH-1:0] full;
        full = $signed({{BIT_WIDTH{a[BIT_WIDTH-1]}}, a}) * $signed({{BIT_WIDTH{b[BIT_WIDTH-1]}}, b});
        return full[DECIMAL_PT +: BIT_WIDTH];
    endfunction

    // One guard bit keeps the scaled sum exact before the floor shift.
    function automatic logic [BIT_WIDTH-1:0] bflyAdd(input logic [BIT_WIDTH-1:0] x,
                                                      input logic [BIT_WIDTH-1:0] y,
                                                      input logic sub);
        logic [BIT_WIDTH:0] wide;
        if (sub) wide = {x[BIT_WIDTH-1], x} - {y[BIT_WIDTH-1], y};
        else     wide = {x[BIT_WIDTH-1], x} + {y[BIT_WIDTH-1], y};
        return (SCALE != 0) ? wide[BIT_WIDTH:1] : wide[BIT_WIDTH-1:0];
    endfunction

    assign w_recvRdy = (r_state == IDLE) || ((r_state == DONE) && bus.send_rdy);
    assign w_accept  = bus.recv_val && w_recvRdy;

    assign bus.recv_rdy      = w_recvRdy;
    assign bus.send_val      = r_sendVal;
    assign bus.send_msg_real = r_workReal;
    assign bus.send_msg_imag = r_workImag;

    always_comb begin
        for (int u = 0; u < N_BFLY; u++) begin
            w_top[u]   = topIndex(int'(r_pass) * N_BFLY + u);
            w_tw[u]    = twiddleIndex(int'(r_pass) * N_BFLY + u);
            w_bot[u]   = w_top[u] + IW'(HALF);
            w_wr[u]    = bus.sine_wave_out[w_tw[u] + IW'(N_SAMPLES / 4)];
            w_wc[u]    = r_inverse ? bus.sine_wave_out[w_tw[u]] : -bus.sine_wave_out[w_tw[u]];
            w_pReal[u] = fxMul(r_workReal[w_bot[u]], w_wr[u]) - fxMul(r_workImag[w_bot[u]], w_wc[u]);
            w_pImag[u] = fxMul(r_workReal[w_bot[u]], w_wc[u]) + fxMul(r_workImag[w_bot[u]], w_wr[u]);
            w_cReal[u] = bflyAdd(r_workReal[w_top[u]], w_pReal[u], 1'b0);
            w_cImag[u] = bflyAdd(r_workImag[w_top[u]], w_pImag[u], 1'b0);
            w_dReal[u] = bflyAdd(r_workReal[w_top[u]], w_pReal[u], 1'b1);
            w_dImag[u] = bflyAdd(r_workImag[w_top[u]], w_pImag[u], 1'b1);
        end
    end

    // Accepting a frame takes priority: it covers both IDLE and a consumed DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_pass     <= '0;
            r_workReal <= '0;
            r_workImag <= '0;
            r_inverse  <= 1'b0;
            r_sendVal  <= 1'b0;
        end else if (w_accept) begin
            r_workReal <= bus.recv_msg_real;
            r_workImag <= bus.recv_msg_imag;
            r_inverse  <= bus.recv_inverse;
            r_pass     <= '0;
            r_sendVal  <= 1'b0;
            r_state    <= CALC;
        end else begin
            case (r_state)
                CALC: begin
                    for (int u = 0; u < N_BFLY; u++) begin
                        r_workReal[w_top[u]] <= w_cReal[u];
                        r_workImag[w_top[u]] <= w_cImag[u];
                        r_workReal[w_bot[u]] <= w_dReal[u];
                        r_workImag[w_bot[u]] <= w_dImag[u];
                    end
                    if (r_pass == PW'(PASSES - 1)) begin
                        r_pass    <= '0;
                        r_sendVal <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_pass <= r_pass + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.send_rdy) begin
                        r_sendVal <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_cooley_tukey_folded_stage.sv
// Drives every stage/parallelism/scaling combination of the folded FFT stage for N=8
// and compares each result frame with a whole-frame arithmetic model of the butterfly stage.
module tb_fft_cooley_tukey_folded_stage;
    localparam int BW   = 32;
    localparam int DP   = 16;
    localparam int NS   = 8;
    localparam int NCFG = 18;
    localparam int FW   = BW * NS;

    typedef logic [NS-1:0][BW-1:0] frame_t;

    logic   clk = 1'b0;
    logic   resetN;
    frame_t sineTable;
    frame_t inReal [NCFG];
    frame_t inImag [NCFG];
    logic   inInv  [NCFG];
    logic   inVal  [NCFG];
    logic   outRdy [NCFG];
    wire         recvRdy [NCFG];
    wire         sendVal [NCFG];
    wire frame_t outReal [NCFG];
    wire frame_t outImag [NCFG];

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    // Config k: stage k%3, 1<<((k/3)%3) butterfly units, scaling when k>=9.
    for (genvar k = 0; k < NCFG; k++) begin : gCfg
        localparam int S  = k % 3;
        localparam int NB = 1 << ((k / 3) % 3);
        localparam int SC = k / 9;

        fft_cooley_tukey_folded_stage_if #(.BIT_WIDTH(BW), .N_SAMPLES(NS)) busInst ();

        assign busInst.recv_msg_real = inReal[k];
        assign busInst.recv_msg_imag = inImag[k];
        assign busInst.recv_inverse  = inInv[k];
        assign busInst.recv_val      = inVal[k];
        assign busInst.send_rdy      = outRdy[k];
        assign busInst.sine_wave_out = sineTable;
        assign recvRdy[k] = busInst.recv_rdy;
        assign sendVal[k] = busInst.send_val;
        assign outReal[k] = busInst.send_msg_real;
        assign outImag[k] = busInst.send_msg_imag;

        fft_cooley_tukey_folded_stage #(
            .BIT_WIDTH(BW), .DECIMAL_PT(DP), .N_SAMPLES(NS),
            .STAGE_FFT(S), .N_BFLY(NB), .SCALE(SC)
        ) dut (
            .clk  (clk),
            .reset(resetN),
            .bus  (busInst.slave)
        );
    end

    function automatic int cfgStage(input int k);
        return k % 3;
    endfunction

    function automatic int cfgScale(input int k);
        return k / 9;
    endfunction

    function automatic int cfgPasses(input int k);
        return NS / (2 * (1 << ((k / 3) % 3)));
    endfunction

    function automatic longint sext(input logic [BW-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint fxMulRef(input longint a, input longint b);
        return sext(BW'((a * b) >>> DP));
    endfunction

    // Whole-frame reference: walk each group of 2H samples and combine pairs H apart.
    function automatic void golden(input int stage, input int scale, input frame_t xr,
                                   input frame_t xi, input logic inv,
                                   output frame_t yr, output frame_t yi);
        int half;
        int span;
        half = 1 << stage;
        span = 2 * half;
        yr = xr;
        yi = xi;
        for (int base = 0; base < NS; base += span) begin
            for (int j = 0; j < half; j++) begin
                int a, t, ix;
                longint wr, wc, pr, pc, sumR, difR, sumI, difI;
                a  = base + j;
                t  = a + half;
                ix = j * NS / span;
                wr = sext(sineTable[(ix + NS / 4) % NS]);
                wc = inv ? sext(sineTable[ix]) : -sext(sineTable[ix]);
                pr = sext(BW'(fxMulRef(sext(xr[t]), wr) - fxMulRef(sext(xi[t]), wc)));
                pc = sext(BW'(fxMulRef(sext(xr[t]), wc) + fxMulRef(sext(xi[t]), wr)));
                sumR = sext(xr[a]) + pr;
                difR = sext(xr[a]) - pr;
                sumI = sext(xi[a]) + pc;
                difI = sext(xi[a]) - pc;
                if (scale != 0) begin
                    sumR = sumR >>> 1;
                    difR = difR >>> 1;
                    sumI = sumI >>> 1;
                    difI = difI >>> 1;
                end
                yr[a] = BW'(sumR);
                yr[t] = BW'(difR);
                yi[a] = BW'(sumI);
                yi[t] = BW'(difI);
            end
        end
    endfunction

    function automatic logic [BW-1:0] randWord();
        int pick;
        pick = int'($urandom_range(0, 5));
        if (pick == 0) return 32'h7FFF_FFFF;
        if (pick == 1) return 32'h8000_0000;
        if (pick == 2) return BW'($urandom_range(0, 32'h0001_FFFF)) - 32'h0001_0000;
        return $urandom();
    endfunction

    task automatic fillRandom(output frame_t re, output frame_t im);
        for (int i = 0; i < NS; i++) begin
            re[i] = randWord();
            im[i] = randWord();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [FW-1:0] observed,
                               input logic [FW-1:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkFrame(input string tag, input int k, input frame_t expRe, input frame_t expIm);
        checkOutput({tag, " real"}, outReal[k], expRe);
        checkOutput({tag, " imag"}, outImag[k], expIm);
    endtask

    // Presents a frame and returns just after the accepting edge; the mode input
    // is flipped afterwards so a design that keeps sampling it would be caught.
    task automatic applyStimulus(input int k, input frame_t re, input frame_t im, input logic inv);
        int waitCycles;
        waitCycles = 0;
        inReal[k] = re;
        inImag[k] = im;
        inInv[k]  = inv;
        inVal[k]  = 1'b1;
        while (recvRdy[k] !== 1'b1 && waitCycles < 50) begin
            tick();
            waitCycles++;
        end
        if (recvRdy[k] !== 1'b1)
            checkOutput($sformatf("accept timeout k%0d", k), FW'(recvRdy[k]), FW'(1'b1));
        tick();
        inVal[k] = 1'b0;
        inInv[k] = ~inv;
        inReal[k] = '0;
        inImag[k] = '0;
    endtask

    task automatic waitOutput(input int k, output int latency);
        latency = 0;
        do begin
            tick();
            latency++;
        end while (sendVal[k] !== 1'b1 && latency < 50);
        if (sendVal[k] !== 1'b1)
            checkOutput($sformatf("send_val timeout k%0d", k), FW'(sendVal[k]), FW'(1'b1));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        frame_t re, im, expRe, expIm, zero;
        int     latency, stall;
        logic   inv, stable, sawVal;

        zero = '0;
        sineTable[0] = 32'h0000_0000;
        sineTable[1] = 32'h0000_B505;
        sineTable[2] = 32'h0001_0000;
        sineTable[3] = 32'h0000_B505;
        sineTable[4] = 32'h0000_0000;
        sineTable[5] = 32'hFFFF_4AFB;
        sineTable[6] = 32'hFFFF_0000;
        sineTable[7] = 32'hFFFF_4AFB;
        resetN = 1'b0;
        for (int k = 0; k < NCFG; k++) begin
            inReal[k] = '0;
            inImag[k] = '0;
            inInv[k]  = 1'b0;
            inVal[k]  = 1'b0;
            outRdy[k] = 1'b1;
        end

        #12;
        checkOutput("reset send_val", FW'(sendVal[0]), FW'(1'b0));
        checkOutput("reset recv_rdy", FW'(recvRdy[0]), FW'(1'b1));
        checkFrame("reset output", 17, zero, zero);
        #2 resetN = 1'b1;
        tick();

        // Stage 0, four units: a single pass sums the two unit samples.
        re = '0; im = '0;
        re[0] = 32'h0001_0000;
        re[1] = 32'h0001_0000;
        applyStimulus(6, re, im, 1'b0);
        waitOutput(6, latency);
        checkOutput("s0 latency", FW'(latency), FW'(1));
        expRe = '0; expIm = '0;
        expRe[0] = 32'h0002_0000;
        checkFrame("s0 unit pair", 6, expRe, expIm);
        tick();

        // Stage 1: x3 meets twiddle -j (forward) or +j (inverse).
        re = '0; im = '0;
        re[3] = 32'h0001_0000;
        applyStimulus(7, re, im, 1'b0);
        waitOutput(7, latency);
        expRe = '0; expIm = '0;
        expIm[1] = 32'hFFFF_0000;
        expIm[3] = 32'h0001_0000;
        checkFrame("s1 forward", 7, expRe, expIm);
        tick();
        applyStimulus(7, re, im, 1'b1);
        waitOutput(7, latency);
        expIm[1] = 32'h0001_0000;
        expIm[3] = 32'hFFFF_0000;
        checkFrame("s1 inverse", 7, expRe, expIm);
        tick();

        // Near-full-scale pair: wraps unscaled, fits exactly when scaled.
        re = '0; im = '0;
        re[0] = 32'h7FFF_0000;
        re[1] = 32'h7FFF_0000;
        applyStimulus(6, re, im, 1'b0);
        waitOutput(6, latency);
        expRe = '0; expIm = '0;
        expRe[0] = 32'hFFFE_0000;
        checkFrame("s0 wrap", 6, expRe, expIm);
        tick();
        applyStimulus(15, re, im, 1'b0);
        waitOutput(15, latency);
        expRe[0] = 32'h7FFF_0000;
        checkFrame("s0 scaled", 15, expRe, expIm);
        tick();

        // One unit, four passes, output held for ten cycles.
        fillRandom(re, im);
        golden(cfgStage(2), cfgScale(2), re, im, 1'b1, expRe, expIm);
        outRdy[2] = 1'b0;
        applyStimulus(2, re, im, 1'b1);
        waitOutput(2, latency);
        checkOutput("stall latency", FW'(latency), FW'(4));
        checkFrame("stall frame", 2, expRe, expIm);
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (sendVal[2] !== 1'b1 || recvRdy[2] !== 1'b0 || outReal[2] !== expRe || outImag[2] !== expIm)
                stable = 1'b0;
        end
        checkOutput("stall hold", FW'(stable), FW'(1'b1));

        fillRandom(re, im);
        golden(cfgStage(2), cfgScale(2), re, im, 1'b0, expRe, expIm);
        inReal[2] = re;
        inImag[2] = im;
        inInv[2]  = 1'b0;
        inVal[2]  = 1'b1;
        outRdy[2] = 1'b1;
        #1;
        checkOutput("done recv_rdy follows send_rdy", FW'(recvRdy[2]), FW'(1'b1));
        tick();
        inVal[2] = 1'b0;
        inInv[2] = 1'b1;
        checkOutput("same-edge accept", FW'({sendVal[2], recvRdy[2]}), FW'(2'b00));
        waitOutput(2, latency);
        checkOutput("back-to-back latency", FW'(latency), FW'(4));
        checkFrame("back-to-back frame", 2, expRe, expIm);
        tick();

        // Reset during pass 2 must clear everything without waiting for a clock.
        fillRandom(re, im);
        applyStimulus(2, re, im, 1'b0);
        tick();
        tick();
        resetN = 1'b0;
        #1;
        checkOutput("reset mid send_val", FW'(sendVal[2]), FW'(1'b0));
        checkFrame("reset mid output", 2, zero, zero);
        #2 resetN = 1'b1;
        tick();
        checkOutput("post-reset recv_rdy", FW'(recvRdy[2]), FW'(1'b1));
        sawVal = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (sendVal[2] !== 1'b0) sawVal = 1'b1;
        end
        checkOutput("no stale frame", FW'(sawVal), FW'(1'b0));

        for (int k = 0; k < NCFG; k++) begin
            for (int f = 0; f < 3; f++) begin
                fillRandom(re, im);
                inv   = 1'($urandom_range(0, 1));
                stall = int'($urandom_range(0, 3));
                golden(cfgStage(k), cfgScale(k), re, im, inv, expRe, expIm);
                outRdy[k] = (stall == 0);
                applyStimulus(k, re, im, inv);
                waitOutput(k, latency);
                checkOutput($sformatf("rand k%0d f%0d latency", k, f), FW'(latency), FW'(cfgPasses(k)));
                checkFrame($sformatf("rand k%0d f%0d", k, f), k, expRe, expIm);
                if (stall > 0) begin
                    for (int c = 0; c < stall; c++) tick();
                    checkFrame($sformatf("rand k%0d f%0d held", k, f), k, expRe, expIm);
                    outRdy[k] = 1'b1;
                end
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule

// File: doc/fft_cooley_tukey_folded_stage.md
# fft_cooley_tukey_folded_stage

Parametrised, time-multiplexed successor to the fully parallel Cooley-Tukey stage. It performs one radix-2 decimation-in-time stage of an N_SAMPLES-point FFT using N_BFLY shared butterfly units, iterating over the N_SAMPLES/2 butterflies in passes. It adds a per-frame inverse mode and optional per-stage 1/2 scaling. Stages chain through the same val/rdy frame interface as the existing cascade.

## Interface
- BIT_WIDTH, 32: two's-complement fixed-point word width.
- DECIMAL_PT, 16: fractional bits.
- N_SAMPLES, 8: FFT size; power of two, at least 4.
- STAGE_FFT, 0: stage index S, 0 to log2(N_SAMPLES)-1.
- N_BFLY, 4: parallel butterfly units; power of two, divides N_SAMPLES/2.
- SCALE, 0: 1 = every butterfly output is arithmetic-shifted right by 1.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- recv_msg_real, recv_msg_imag  in  BIT_WIDTH x N_SAMPLES  input frame, bit-reversed order.
- recv_inverse  in  1  frame mode, sampled with the frame (1 = inverse/conjugate twiddles).
- recv_val  in  1; recv_rdy  out  1.
- send_msg_real, send_msg_imag  out  BIT_WIDTH x N_SAMPLES  result frame.
- send_val  out  1; send_rdy  in  1.
- sine_wave_out  in  BIT_WIDTH x N_SAMPLES  static table, entry k = sin(2πk/N_SAMPLES).

## Operation
- P = N_SAMPLES/(2·N_BFLY) passes per frame. H = 2^S, G = 2H.
- Butterfly b: j = b mod H, top a = (b/H)·G + j, bottom t = a + H. Computes in place on indices a and t.
- Twiddle index IX = j·N_SAMPLES/G. wr = sine_wave_out[(IX + N_SAMPLES/4) mod N_SAMPLES]. wc = −sine_wave_out[IX], or +sine_wave_out[IX] when the latched inverse bit is 1.
- Multiply: fixed product = bits [DECIMAL_PT +: BIT_WIDTH] of the full 2·BIT_WIDTH signed product (floor).
- pr = mul(tr,wr) − mul(tc,wc); pc = mul(tr,wc) + mul(tc,wr).
- Outputs: c = x[a] + p, d = x[a] − p.
  - SCALE=0: sums wrap modulo 2^BIT_WIDTH.
  - SCALE=1: sums formed at BIT_WIDTH+1 bits, then arithmetic shift right 1 (floor); never overflows.
- Pass p handles butterflies p·N_BFLY to p·N_BFLY+N_BFLY−1. Butterflies in a stage are disjoint, so writing in place is safe.
- FSM:
  - IDLE: recv_rdy=1. On recv_val, capture the frame into the work buffer, latch recv_inverse, set pass=0, go to CALC.
  - CALC: one pass per cycle. After pass P−1, go to DONE.
  - DONE: send_val=1 and send_msg = work buffer. recv_rdy = send_rdy.
    - send_rdy=1 and recv_val=1: capture the new frame and go to CALC.
    - send_rdy=1 and recv_val=0: go to IDLE.
    - send_rdy=0: hold.
- Reset (async, any state): state=IDLE, pass=0, work buffer=0, inverse latch=0. send_val=0, send_msg all zero, recv_rdy=1.
- Reset asserted mid-frame aborts the frame; no partial output is ever presented.

## Timing
- Frame accepted at edge E0 → send_val high after edge E_P, i.e. P cycles later.
- Throughput with send_rdy held high and back-to-back input: one frame per P+1 cycles.
- recv_rdy is 0 throughout CALC.
- send_msg and send_val are stable while send_val=1 and send_rdy=0.
- recv_rdy in DONE depends combinationally on send_rdy only. There is no path from recv_val to recv_rdy.
- recv_inverse is only sampled on the accept edge.

## Test plan
- Stage 0, N_BFLY=4, SCALE=0: x0=x1=0x00010000, all other inputs 0 → send_val one cycle after accept; out0=0x00020000, out1=0, rest 0.
- Stage 1: x1 imag=0, x3=0x00010000 real (twiddle −j), x1=0 → out1=(0, 0xFFFF0000), out3=(0, 0x00010000).
  - Same frame with recv_inverse=1 → the signs of the two imaginary outputs swap.
- Stage 0, x0=x1=0x7FFF0000 real:
  - SCALE=0 → out0=0xFFFE0000 (wrap).
  - SCALE=1 → out0=0x7FFF0000, out1=0.
- N_BFLY=1 (P=4): send_rdy held low 10 cycles after send_val → outputs constant, recv_rdy=0.
  - Then send_rdy=1 with recv_val=1 → new frame accepted on the same edge; next send_val exactly 4 cycles later.
- Reset pulled low in CALC pass 2 → send_val=0 and outputs zero immediately (asynchronously).
  - After release: recv_rdy=1 and no stale frame is emitted.
- Random frames for all S, N_BFLY ∈ {1,2,4}, both modes, both SCALE values → bit-exact match to the golden model, including stalls.
